matrix_stream_reader: RTL and testbench

- Read-side initiator for the 12-bit data memory: walks a rectangular matrix region (base, rows, cols, row stride) and streams each word out over a valid/ready interface.
- Drives the memory's addr/write_en/datain and consumes its registered dataout (one-cycle read latency).
- Sits between the data memory port mux and the result output path (UART/display); used after the matrix multiply completes to dump the result matrix.

---
 rtl/matrix_stream_reader_pkg.sv | 19 +
 rtl/matrix_addr_gen.sv | 83 ++++++++
 rtl/matrix_stream_reader.sv | 142 ++++++++++++++
 tb/tb_matrix_stream_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_reader_pkg.sv
// rtl/matrix_stream_reader_pkg.sv - shared widths, FSM encoding and defaults for the matrix stream reader
package matrix_stream_reader_pkg;

  // Memory address/data width and streamed word width
  localparam int N_DEF = 12;
  localparam int W_DEF = 12;

  // Typical spacing between row starts of a stored matrix
  localparam logic [N_DEF-1:0] DEFAULT_STRIDE = 12'd64;

  // FSM encoding
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

endpackage

// File: rtl/matrix_addr_gen.sv
// rtl/matrix_addr_gen.sv - row/col walker producing the current element address and last flag
module matrix_addr_gen
  import matrix_stream_reader_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  input  logic [N-1:0] base_addr,
  input  logic [N-1:0] row_count,
  input  logic [N-1:0] col_count,
  input  logic [N-1:0] row_stride,
  output logic [N-1:0] addr,
  output logic         is_last
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] row_base_q, row_base_d;
  logic [N-1:0] col_q, col_d;
  logic [N-1:0] row_q, row_d;
  logic [N-1:0] rows_q, rows_d;
  logic [N-1:0] cols_q, cols_d;
  logic [N-1:0] stride_q, stride_d;
  logic         col_last;
  logic         row_last;

  // Address is the row start plus column offset; wraps naturally at N bits
  always_comb begin
    addr     = row_base_q + col_q;
    col_last = (col_q == cols_q - ONE);
    row_last = (row_q == rows_q - ONE);
    is_last  = col_last && row_last;
  end

  // Next-state: load captures the region, advance steps col then row
  always_comb begin
    row_base_d = row_base_q;
    col_d      = col_q;
    row_d      = row_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    stride_d   = stride_q;
    if (load) begin
      rows_d     = row_count;
      cols_d     = col_count;
      stride_d   = row_stride;
      row_base_d = base_addr;
      col_d      = '0;
      row_d      = '0;
    end else if (advance) begin
      if (col_last) begin
        col_d      = '0;
        row_d      = row_q + ONE;
        row_base_d = row_base_q + stride_q;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  // Counter and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      stride_q   <= '0;
    end else begin
      row_base_q <= row_base_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      stride_q   <= stride_d;
    end
  end

endmodule

// File: rtl/matrix_stream_reader.sv
// rtl/matrix_stream_reader.sv - walks a matrix region in data memory and streams each word out
module matrix_stream_reader
  import matrix_stream_reader_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] base_addr,
  input  logic [N-1:0] row_count,
  input  logic [N-1:0] col_count,
  input  logic [N-1:0] row_stride,
  output logic [N-1:0] mem_addr,
  output logic         mem_write_en,
  output logic [N-1:0] mem_datain,
  input  logic [N-1:0] mem_dataout,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  state_t       state_q, state_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         gen_load;
  logic         gen_advance;
  logic [N-1:0] gen_addr;
  logic         gen_last;

  matrix_addr_gen #(.N(N)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (gen_load),
    .advance    (gen_advance),
    .base_addr  (base_addr),
    .row_count  (row_count),
    .col_count  (col_count),
    .row_stride (row_stride),
    .addr       (gen_addr),
    .is_last    (gen_last)
  );

  // The reader never writes memory
  assign mem_write_en = 1'b0;
  assign mem_datain   = '0;

  // Address is presented combinationally during READ and held otherwise
  assign mem_addr  = mem_addr_d;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // FSM: one read, one capture, one handshake per word; no read pipelining
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    gen_load    = 1'b0;
    gen_advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if ((row_count != '0) && (col_count != '0)) begin
            gen_load = 1'b1;
            state_d  = ST_READ;
          end else begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_READ: begin
        mem_addr_d = gen_addr;
        state_d    = ST_LATCH;
      end
      ST_LATCH: begin
        out_data_d  = mem_dataout[W-1:0];
        out_valid_d = 1'b1;
        out_last_d  = gen_last;
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            gen_advance = 1'b1;
            state_d     = ST_READ;
          end
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any dump in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_matrix_stream_reader.sv
// tb/tb_matrix_stream_reader.sv - scoreboard bench for the matrix stream reader
module tb_matrix_stream_reader;
  import matrix_stream_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] base_addr, row_count, col_count, row_stride;
  logic [11:0] mem_addr, mem_datain, mem_dataout, out_data;
  logic        mem_write_en, out_valid, out_ready, out_last, busy, done;

  matrix_stream_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .row_count    (row_count),
    .col_count    (col_count),
    .row_stride   (row_stride),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_datain   (mem_datain),
    .mem_dataout  (mem_dataout),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [0:4095];
  always @(posedge clk) mem_dataout <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [12:0] exp_q[$];
  logic [11:0] exp_addr_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int addr_chg = 0;
  int start_cyc = 0;
  int done_ref = 0;
  logic [11:0] prev_addr;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Output scoreboard: compare every accepted word against the model
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      valid_cnt++;
      if (out_ready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          logic [12:0] e;
          e = exp_q.pop_front();
          check("out_data", out_data, e[11:0]);
          check("out_last", out_last, e[12]);
        end
      end
    end
  end

  // Address scoreboard: every new mem_addr value must be the next expected read
  always @(negedge clk) begin
    if (rst) begin
      prev_addr = mem_addr;
    end else if (mem_addr !== prev_addr) begin
      addr_chg++;
      check("addr_expected", exp_addr_q.size() != 0, 1);
      if (exp_addr_q.size() != 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
      prev_addr = mem_addr;
    end
  end

  always @(negedge clk) if (!rst && done === 1'b1) done_cnt++;

  task automatic kick(int b, int r, int c, int s);
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < c; j++) begin
        logic [11:0] a;
        a = 12'((b + i * s + j) % 4096);
        exp_addr_q.push_back(a);
        exp_q.push_back({(i == r - 1) && (j == c - 1), mem[a]});
      end
    end
    done_ref   = done_cnt;
    base_addr  = 12'(b);
    row_count  = 12'(r);
    col_count  = 12'(c);
    row_stride = 12'(s);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic finish_check(string tag, int lo, int hi);
    int lat;
    int n;
    lat = -1;
    n   = 0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) begin
        lat = cyc - start_cyc + 1;
        break;
      end
    end
    check({tag, "_done_seen"}, lat >= 0, 1);
    check({tag, "_latency_ok"}, (lat >= lo) && (lat <= hi), 1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_pulse"}, done, 0);
    repeat (2) @(negedge clk);
    check({tag, "_done_count"}, done_cnt - done_ref, 1);
    check({tag, "_words_left"}, exp_q.size(), 0);
    check({tag, "_addrs_left"}, exp_addr_q.size(), 0);
  endtask

  task automatic wait_word(logic [11:0] val);
    int n;
    n = 0;
    while (!(out_valid === 1'b1 && out_data === val) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("word_reached", n < 100, 1);
  endtask

  initial begin
    int v0, a0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    base_addr = '0; row_count = '0; col_count = '0; row_stride = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[4] = 12'd1; mem[5] = 12'd2; mem[68] = 12'd3; mem[69] = 12'd4;
    mem[4095] = 12'd7; mem[0] = 12'd9;

    repeat (2) @(negedge clk);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write_en", mem_write_en, 0);
    check("rst_datain", mem_datain, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Basic 2x2 dump with the sink always ready
    kick(4, 2, 2, 64);
    check("basic_busy", busy, 1);
    check("basic_write_en", mem_write_en, 0);
    finish_check("basic", 13, 13);

    // Backpressure: hold word 2 for five cycles
    kick(4, 2, 2, int'(DEFAULT_STRIDE));
    wait_word(12'd2);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 2);
      check("stall_last", out_last, 0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    finish_check("stall", 18, 18);

    // Empty region: zero rows, then zero columns
    v0 = valid_cnt; a0 = addr_chg;
    kick(4, 0, 2, 64);
    finish_check("zero_rows", 1, 2);
    check("zero_rows_no_valid", valid_cnt - v0, 0);
    check("zero_rows_no_addr", addr_chg - a0, 0);
    v0 = valid_cnt; a0 = addr_chg;
    kick(4, 2, 0, 64);
    finish_check("zero_cols", 1, 2);
    check("zero_cols_no_valid", valid_cnt - v0, 0);
    check("zero_cols_no_addr", addr_chg - a0, 0);

    // Address wrap from the top of memory
    kick(4095, 1, 2, 64);
    finish_check("wrap", 7, 7);

    // A second start while busy is ignored
    kick(4, 2, 2, 64);
    base_addr = 12'd100; row_count = 12'd3; col_count = 12'd3;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    finish_check("restart_ignored", 13, 13);

    // Asynchronous reset in the middle of word 2, then a full replay
    kick(4, 2, 2, 64);
    wait_word(12'd2);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_mem_addr", mem_addr, 0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    kick(4, 2, 2, 64);
    finish_check("replay", 13, 13);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
